// File: rtl/pmem_arbiter_n.sv
// -----------------------------------------------------------------------------
// pmem_arbiter_n
//
// Serialises line reads and writes from NUM_CH requester channels onto a
// single physical-memory port. Besides plain arbitration it provides:
//   * a selectable grant policy (fixed priority or round robin),
//   * read-after-write ordering: a read never overtakes a pending write to
//     the same line,
//   * read merging: every channel reading the granted line when the
//     transaction completes is answered by the same memory read.
//
// Optional feature macro:
//   PMEM_ARB_RR_EN  defined   -> round-robin grant policy with a pointer
//                   undefined -> fixed priority, channel 0 highest
//
// Parameters:
//   NUM_CH  number of requester channels
//   LINE_W  line width in bits (power of two, >= 64)
//   ADDR_W  byte address width
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   req_read      per-channel read request, held until req_resp
//   req_write     per-channel write request, held until req_resp
//   req_addr      channel i address in [i*ADDR_W +: ADDR_W]
//   req_wdata     channel i write line in [i*LINE_W +: LINE_W]
//   req_resp      one-cycle completion pulse per channel
//   rdata         registered read line, valid with req_resp of a read
//   pmem_read     memory read command
//   pmem_write    memory write command
//   pmem_address  registered address of the granted request
//   pmem_wdata    registered write line of the granted request
//   pmem_resp     memory completion
//   pmem_rdata    memory read line
// -----------------------------------------------------------------------------
module pmem_arbiter_n #(
  parameter int NUM_CH = 3,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic [LINE_W-1:0]        rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata
);

  // Byte-offset bits inside a line; addresses match on the bits above them.
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int LINE_A = ADDR_W - OFF;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_READ,
    ST_WRITE,
    ST_FINISH
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Latched grant: channel index and whether it is a write.
  logic [CH_W-1:0] grant_ch_reg;
  logic            grant_write_reg;

  // Per-channel views of the packed request buses.
  logic [ADDR_W-1:0] ch_addr  [NUM_CH];
  logic [LINE_W-1:0] ch_wdata [NUM_CH];
  logic [LINE_A-1:0] ch_line  [NUM_CH];

  logic [NUM_CH-1:0] req_any;
  logic [NUM_CH-1:0] haz_vec;    // writes to the policy winner's line
  logic [NUM_CH-1:0] merge_hit;  // reads to the granted line
  logic [NUM_CH-1:0] grant_oh;

  logic [CH_W-1:0]   pick_ch;    // policy winner before hazard override
  logic [CH_W-1:0]   win_ch;     // final winner
  logic [LINE_A-1:0] pick_line;

  assign req_any = req_read | req_write;

  // ---------------------------------------------------------------------------
  // Channel unpacking and line comparisons
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign ch_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
      assign ch_line[gi]  = ch_addr[gi][ADDR_W-1:OFF];

      assign haz_vec[gi]   = req_write[gi] && (ch_line[gi] == pick_line);
      // pmem_address holds the granted address from READ onwards, so it is
      // the reference line for merging in FINISH.
      assign merge_hit[gi] = req_read[gi] &&
                             (ch_line[gi] == pmem_address[ADDR_W-1:OFF]);
      assign grant_oh[gi]  = (grant_ch_reg == CH_W'(gi));
    end
  endgenerate

  assign pick_line = ch_line[pick_ch];

  // ---------------------------------------------------------------------------
  // Grant policy
  // ---------------------------------------------------------------------------
`ifdef PMEM_ARB_RR_EN
  // Holds the channel where the next search starts, i.e. one past the last
  // granted channel. Reset value 0 makes channel 0 the first candidate.
  logic [CH_W-1:0] rr_ptr_reg;

  always_comb begin : p_policy_rr
    int   cand;
    logic found;
    pick_ch = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!found && req_any[cand]) begin
        pick_ch = CH_W'(cand);
        found   = 1'b1;
      end
    end
  end

  // The pointer follows the latched grant, so a hazard override moves it
  // to the overriding write channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == ST_GRANT) begin
      if (grant_ch_reg == CH_W'(NUM_CH - 1)) begin
        rr_ptr_reg <= '0;
      end else begin
        rr_ptr_reg <= grant_ch_reg + CH_W'(1);
      end
    end
  end
`else
  // Fixed priority: lowest-index requesting channel.
  always_comb begin : p_policy_fixed
    pick_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_any[i]) begin
        pick_ch = CH_W'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read-after-write override: a read winner yields to the lowest-index
  // channel holding a write to the same line.
  // ---------------------------------------------------------------------------
  always_comb begin : p_override
    logic hz_found;
    win_ch   = pick_ch;
    hz_found = 1'b0;
    if (req_read[pick_ch]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!hz_found && haz_vec[i]) begin
          win_ch   = CH_W'(i);
          hz_found = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Commands and responses are decoded from the state register so that an
  // asynchronous reset clears them in the same cycle.
  always_comb begin : p_fsm
    state_next = state_reg;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    req_resp   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_any) begin
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_next = grant_write_reg ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          state_next = ST_FINISH;
        end
      end
      ST_WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        req_resp   = grant_oh | (grant_write_reg ? '0 : merge_hit);
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant and datapath registers
  // ---------------------------------------------------------------------------
  // The winner is chosen from the IDLE-cycle requests; the command fields are
  // captured one cycle later from the latched channel, which still holds its
  // request, and then stay frozen until the next GRANT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_ch_reg    <= '0;
      grant_write_reg <= 1'b0;
      pmem_address    <= '0;
      pmem_wdata      <= '0;
      rdata           <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_any) begin
            grant_ch_reg    <= win_ch;
            grant_write_reg <= req_write[win_ch];
          end
        end
        ST_GRANT: begin
          pmem_address <= ch_addr[grant_ch_reg];
          if (grant_write_reg) begin
            pmem_wdata <= ch_wdata[grant_ch_reg];
          end
        end
        ST_READ: begin
          rdata <= pmem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
